// File: rtl/boot_mode_ctrl_if.sv
// Board-side signal bundle for boot_mode_ctrl: PLL lock, button, USB/DFU status in,
// bootloader ownership and board reset controls out.
interface boot_mode_ctrl_if;
    logic       clk_locked;
    logic       pwr_button;
    logic       usb_reset;
    logic [7:0] dfu_state;
    logic       user_bootmode;
    logic       dfu_core_reset;
    logic       usb_pull_en;
    logic       target_rst_drive;
    logic       button_press;

    modport master (
        output clk_locked, pwr_button, usb_reset, dfu_state,
        input  user_bootmode, dfu_core_reset, usb_pull_en, target_rst_drive, button_press
    );

    modport slave (
        input  clk_locked, pwr_button, usb_reset, dfu_state,
        output user_bootmode, dfu_core_reset, usb_pull_en, target_rst_drive, button_press
    );
endinterface

// File: rtl/boot_mode_ctrl.sv
// Boot-mode controller: debounced power button, PLL-lock gated board reset, DFU handoff.
// Optional macro BOOT_MODE_LONG_PRESS_EN: RUN->BOOT needs a long press instead of any press.
module boot_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 480000,
    parameter int POR_HOLD_CYCLES   = 65535,
    parameter int EXIT_HOLD_CYCLES  = 4800,
    parameter int LONG_PRESS_CYCLES = 96000000
) (
    input logic            clk_48mhz,
    input logic            resetn,
    boot_mode_ctrl_if.slave bus
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int POR_W  = $clog2(POR_HOLD_CYCLES + 1);
    localparam int EXIT_W = $clog2(EXIT_HOLD_CYCLES + 1);
    localparam int CNT_W  = (POR_W > EXIT_W) ? POR_W : EXIT_W;
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  POR_LOAD  = CNT_W'(POR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EXIT_LOAD = CNT_W'(EXIT_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [2:0] {
        LOCK_WAIT,
        POR_HOLD,
        RUN,
        BOOT,
        EXIT
    } state_t;

    // ---------------------------------------------------------------
    // Two-flop synchronisers
    // ---------------------------------------------------------------
    logic btn_s1, btn_s2, lock_s1, lock_s2;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            btn_s1  <= 1'b1;
            btn_s2  <= 1'b1;
            lock_s1 <= 1'b1;
            lock_s2 <= 1'b1;
        end else begin
            btn_s1  <= bus.pwr_button;
            btn_s2  <= btn_s1;
            lock_s1 <= bus.clk_locked;
            lock_s2 <= lock_s1;
        end
    end

    // ---------------------------------------------------------------
    // Debounce: the level follows only after a full run of disagreement
    // ---------------------------------------------------------------
    logic             deb_lvl;
    logic [DEB_W-1:0] deb_cnt;
    logic             press_q;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            deb_lvl <= 1'b1;
            deb_cnt <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (btn_s2 != deb_lvl) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_lvl <= btn_s2;
                    deb_cnt <= '0;
                    press_q <= ~btn_s2;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Ownership FSM
    // ---------------------------------------------------------------
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              boot_req;

`ifdef BOOT_MODE_LONG_PRESS_EN
    assign boot_req = ~deb_lvl && (hold_q == HOLD_LAST);
`else
    assign boot_req = press_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = '0;
        if (!lock_s2) begin
            state_d = LOCK_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOCK_WAIT: begin
                    state_d = POR_HOLD;
                    cnt_d   = POR_LOAD;
                end
                POR_HOLD: begin
                    if (cnt_q == '0) state_d = deb_lvl ? RUN : BOOT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                RUN: begin
                    // Hold counter only runs while pressed in RUN; saturates at its terminal value
                    if (!deb_lvl && hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
                    if (boot_req) begin
                        state_d = BOOT;
                        hold_d  = '0;
                    end
                end
                BOOT: begin
                    if (bus.usb_reset && bus.dfu_state == 8'h01) begin
                        state_d = EXIT;
                        cnt_d   = EXIT_LOAD;
                    end
                end
                EXIT: begin
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d = LOCK_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they track the state register exactly.
    logic ub_q, dcr_q, pull_q, trd_q;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOCK_WAIT;
            cnt_q   <= '0;
            hold_q  <= '0;
            ub_q    <= 1'b0;
            dcr_q   <= 1'b1;
            pull_q  <= 1'b0;
            trd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ub_q    <= (state_d == BOOT);
            dcr_q   <= (state_d != BOOT);
            pull_q  <= (state_d == BOOT);
            trd_q   <= (state_d != RUN);
        end
    end

    assign bus.user_bootmode    = ub_q;
    assign bus.dfu_core_reset   = dcr_q;
    assign bus.usb_pull_en      = pull_q;
    assign bus.target_rst_drive = trd_q;
    assign bus.button_press     = press_q;

endmodule
